// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings, control bundle type and small helpers for the pipeline control unit.
package pipe_ctrl_pkg;

    // Primary opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes (instruction[5:0])
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_REG    = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        DST_RD = 2'b00,
        DST_RT = 2'b01,
        DST_RA = 2'b10
    } regdst_e;

    typedef enum logic [1:0] {
        M2R_ALU = 2'b00,
        M2R_MEM = 2'b01,
        M2R_PC4 = 2'b10
    } memtoreg_e;

    typedef struct packed {
        pcsrc_e    pcsrc;
        regdst_e   regdst;
        logic      regwrite;
        logic      memread;
        logic      memwrite;
        memtoreg_e memtoreg;
        logic      alusrc1;
        logic      alusrc2;
        logic      extop;
        logic      luop;
        logic      branch;
        logic      is_jump;    // j, jal, jr, jalr
        logic      reads_rt;   // rt is a true source operand
        logic      is_mdu;     // mult/multu/div/divu
        logic      reads_mdu;  // mfhi/mflo
    } ctrl_bundle_t;

    // Pick the architectural write register from the RegDst selector.
    function automatic logic [4:0] resolve_dst(input regdst_e sel, input logic [4:0] rt,
                                               input logic [4:0] rd);
        logic [4:0] dst;
        case (sel)
            DST_RA:  dst = 5'd31;
            DST_RT:  dst = rt;
            DST_RD:  dst = rd;
            default: dst = 5'd0;
        endcase
        return dst;
    endfunction

    // True when a live producer register collides with an ID-stage source.
    function automatic logic src_match(input logic [4:0] dst, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic uses_rt);
        return (dst != 5'd0) && ((dst == rs) || (uses_rt && (dst == rt)));
    endfunction

endpackage

// File: rtl/pipe_ctrl_ctrl_decode.sv
// Combinational opcode/funct decoder producing the ID-stage control bundle.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int ENABLE_MDU = 1
) (
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output ctrl_bundle_t ctrl
);

    // Map opcode/funct to the control bundle; unknown encodings decode as NOP.
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA: begin
                        ctrl.regwrite = 1'b1;
                        ctrl.regdst   = DST_RD;
                        ctrl.alusrc1  = 1'b1;
                        ctrl.reads_rt = 1'b1;
                    end
                    FN_JR: begin
                        ctrl.pcsrc   = PC_REG;
                        ctrl.is_jump = 1'b1;
                    end
                    FN_JALR: begin
                        ctrl.pcsrc    = PC_REG;
                        ctrl.is_jump  = 1'b1;
                        ctrl.regwrite = 1'b1;
                        ctrl.regdst   = DST_RD;
                        ctrl.memtoreg = M2R_PC4;
                    end
                    FN_MFHI, FN_MFLO: begin
                        ctrl.regwrite  = 1'b1;
                        ctrl.regdst    = DST_RD;
                        ctrl.reads_mdu = 1'b1;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        if (ENABLE_MDU != 0) begin
                            ctrl.is_mdu   = 1'b1;
                            ctrl.reads_rt = 1'b1;
                        end else begin
                            ctrl = '0;
                        end
                    end
                    default: begin
                        ctrl.regwrite = 1'b1;
                        ctrl.regdst   = DST_RD;
                        ctrl.reads_rt = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = DST_RT;
                ctrl.alusrc2  = 1'b1;
                ctrl.extop    = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = M2R_MEM;
            end
            OP_SW: begin
                ctrl.memwrite = 1'b1;
                ctrl.alusrc2  = 1'b1;
                ctrl.extop    = 1'b1;
                ctrl.reads_rt = 1'b1;
            end
            OP_LUI: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = DST_RT;
                ctrl.alusrc2  = 1'b1;
                ctrl.luop     = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = DST_RT;
                ctrl.alusrc2  = 1'b1;
                ctrl.extop    = 1'b1;
            end
            OP_ANDI: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = DST_RT;
                ctrl.alusrc2  = 1'b1;
            end
            OP_BEQ: begin
                ctrl.pcsrc    = PC_BRANCH;
                ctrl.branch   = 1'b1;
                ctrl.extop    = 1'b1;
                ctrl.reads_rt = 1'b1;
            end
            OP_J: begin
                ctrl.pcsrc   = PC_JUMP;
                ctrl.is_jump = 1'b1;
            end
            OP_JAL: begin
                ctrl.pcsrc    = PC_JUMP;
                ctrl.is_jump  = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = DST_RA;
                ctrl.memtoreg = M2R_PC4;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: ID decode, stage control registers, hazard/stall/flush and MDU busy tracking.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = 4,
    parameter int ENABLE_MDU  = 1,
    parameter int FWD_ENABLE  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [5:0] id_opcode,
    input  logic [5:0] id_funct,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] id_rd,
    input  logic       ex_branch_taken,
    output logic [1:0] id_pcsrc,
    output logic       stall,
    output logic       flush_if_id,
    output logic       ex_alusrc1,
    output logic       ex_alusrc2,
    output logic       ex_extop,
    output logic       ex_luop,
    output logic       ex_branch,
    output logic       mem_memread,
    output logic       mem_memwrite,
    output logic       wb_regwrite,
    output logic [1:0] wb_memtoreg,
    output logic [4:0] wb_dst,
    output logic       mdu_busy
);

    ctrl_bundle_t dec_s;
    logic [4:0]   id_dst_s;
    logic         id_regwrite_s;
    logic         hazard_s;
    logic         issue_s;
    logic [3:0]   mdu_cnt_next_s;

    logic         ex_memread_r;
    logic         ex_memwrite_r;
    logic         ex_regwrite_r;
    logic [1:0]   ex_memtoreg_r;
    logic [4:0]   ex_dst_r;
    logic         mem_regwrite_r;
    logic [1:0]   mem_memtoreg_r;
    logic [4:0]   mem_dst_r;
    logic [3:0]   mdu_cnt_r;
    logic         mdu_busy_r;

    ctrl_decode #(.ENABLE_MDU(ENABLE_MDU)) u_decode (
        .opcode (id_opcode),
        .funct  (id_funct),
        .ctrl   (dec_s)
    );

    // Resolve the write register in ID; a $0 destination carries no write and a zero dst.
    always_comb begin
        if (dec_s.regwrite && (resolve_dst(dec_s.regdst, id_rt, id_rd) != 5'd0)) begin
            id_regwrite_s = 1'b1;
            id_dst_s      = resolve_dst(dec_s.regdst, id_rt, id_rd);
        end else begin
            id_regwrite_s = 1'b0;
            id_dst_s      = 5'd0;
        end
    end

    // Hazard detection, stall/flush generation and next-PC select; a taken branch overrides stall.
    always_comb begin
        hazard_s = 1'b0;
        if (id_valid) begin
            if (ex_memread_r && src_match(ex_dst_r, id_rs, id_rt, dec_s.reads_rt)) begin
                hazard_s = 1'b1;
            end else if ((FWD_ENABLE == 0) &&
                         (src_match(ex_dst_r, id_rs, id_rt, dec_s.reads_rt) ||
                          src_match(mem_dst_r, id_rs, id_rt, dec_s.reads_rt))) begin
                hazard_s = 1'b1;
            end else if (mdu_busy_r && (dec_s.is_mdu || dec_s.reads_mdu)) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = 1'b0;
            end
        end else begin
            hazard_s = 1'b0;
        end
        stall       = hazard_s && !ex_branch_taken;
        flush_if_id = (id_valid && dec_s.is_jump) || ex_branch_taken;
        issue_s     = id_valid && !hazard_s && !ex_branch_taken;
        if (id_valid) begin
            id_pcsrc = dec_s.pcsrc;
        end else begin
            id_pcsrc = 2'b00;
        end
    end

    // Stage control registers: ID/EX takes the decode or a bubble, EX/MEM and MEM/WB always advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_alusrc1     <= 1'b0;
            ex_alusrc2     <= 1'b0;
            ex_extop       <= 1'b0;
            ex_luop        <= 1'b0;
            ex_branch      <= 1'b0;
            ex_memread_r   <= 1'b0;
            ex_memwrite_r  <= 1'b0;
            ex_regwrite_r  <= 1'b0;
            ex_memtoreg_r  <= 2'b00;
            ex_dst_r       <= 5'd0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            mem_regwrite_r <= 1'b0;
            mem_memtoreg_r <= 2'b00;
            mem_dst_r      <= 5'd0;
            wb_regwrite    <= 1'b0;
            wb_memtoreg    <= 2'b00;
            wb_dst         <= 5'd0;
        end else begin
            if (issue_s) begin
                ex_alusrc1    <= dec_s.alusrc1;
                ex_alusrc2    <= dec_s.alusrc2;
                ex_extop      <= dec_s.extop;
                ex_luop       <= dec_s.luop;
                ex_branch     <= dec_s.branch;
                ex_memread_r  <= dec_s.memread;
                ex_memwrite_r <= dec_s.memwrite;
                ex_regwrite_r <= id_regwrite_s;
                ex_memtoreg_r <= dec_s.memtoreg;
                ex_dst_r      <= id_dst_s;
            end else begin
                ex_alusrc1    <= 1'b0;
                ex_alusrc2    <= 1'b0;
                ex_extop      <= 1'b0;
                ex_luop       <= 1'b0;
                ex_branch     <= 1'b0;
                ex_memread_r  <= 1'b0;
                ex_memwrite_r <= 1'b0;
                ex_regwrite_r <= 1'b0;
                ex_memtoreg_r <= 2'b00;
                ex_dst_r      <= 5'd0;
            end
            mem_memread    <= ex_memread_r;
            mem_memwrite   <= ex_memwrite_r;
            mem_regwrite_r <= ex_regwrite_r;
            mem_memtoreg_r <= ex_memtoreg_r;
            mem_dst_r      <= ex_dst_r;
            wb_regwrite    <= mem_regwrite_r;
            wb_memtoreg    <= mem_memtoreg_r;
            wb_dst         <= mem_dst_r;
        end
    end

    // MDU occupancy: reload when an MDU op issues into EX, otherwise count down to zero.
    always_comb begin
        if (ENABLE_MDU == 0) begin
            mdu_cnt_next_s = 4'd0;
        end else if (issue_s && dec_s.is_mdu) begin
            mdu_cnt_next_s = 4'(MDU_LATENCY);
        end else if (mdu_cnt_r != 4'd0) begin
            mdu_cnt_next_s = mdu_cnt_r - 4'd1;
        end else begin
            mdu_cnt_next_s = mdu_cnt_r;
        end
    end

    // MDU counter and its registered busy flag; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            mdu_cnt_r  <= 4'd0;
            mdu_busy_r <= 1'b0;
        end else begin
            mdu_cnt_r  <= mdu_cnt_next_s;
            mdu_busy_r <= (mdu_cnt_next_s != 4'd0);
        end
    end

    assign mdu_busy = mdu_busy_r;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit (default config plus a no-forwarding instance).
module tb_pipe_ctrl_unit;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic [5:0] id_funct;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;
    logic       ex_branch_taken;

    logic [1:0] id_pcsrc;
    logic       stall, flush_if_id;
    logic       ex_alusrc1, ex_alusrc2, ex_extop, ex_luop, ex_branch;
    logic       mem_memread, mem_memwrite;
    logic       wb_regwrite;
    logic [1:0] wb_memtoreg;
    logic [4:0] wb_dst;
    logic       mdu_busy;

    logic [1:0] nf_id_pcsrc;
    logic       nf_stall, nf_flush_if_id;
    logic       nf_ex_alusrc1, nf_ex_alusrc2, nf_ex_extop, nf_ex_luop, nf_ex_branch;
    logic       nf_mem_memread, nf_mem_memwrite;
    logic       nf_wb_regwrite;
    logic [1:0] nf_wb_memtoreg;
    logic [4:0] nf_wb_dst;
    logic       nf_mdu_busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pipe_ctrl_unit u_dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_branch_taken(ex_branch_taken), .id_pcsrc(id_pcsrc), .stall(stall),
        .flush_if_id(flush_if_id), .ex_alusrc1(ex_alusrc1), .ex_alusrc2(ex_alusrc2),
        .ex_extop(ex_extop), .ex_luop(ex_luop), .ex_branch(ex_branch),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .wb_regwrite(wb_regwrite),
        .wb_memtoreg(wb_memtoreg), .wb_dst(wb_dst), .mdu_busy(mdu_busy)
    );

    pipe_ctrl_unit #(.FWD_ENABLE(0)) u_nf (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_branch_taken(ex_branch_taken), .id_pcsrc(nf_id_pcsrc), .stall(nf_stall),
        .flush_if_id(nf_flush_if_id), .ex_alusrc1(nf_ex_alusrc1), .ex_alusrc2(nf_ex_alusrc2),
        .ex_extop(nf_ex_extop), .ex_luop(nf_ex_luop), .ex_branch(nf_ex_branch),
        .mem_memread(nf_mem_memread), .mem_memwrite(nf_mem_memwrite),
        .wb_regwrite(nf_wb_regwrite), .wb_memtoreg(nf_wb_memtoreg), .wb_dst(nf_wb_dst),
        .mdu_busy(nf_mdu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_valid  = v;
        id_opcode = op;
        id_funct  = fn;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
    endtask

    task automatic idle();
        instr(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        reset = 1'b1;
        ex_branch_taken = 1'b0;
        idle();
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_ex_alusrc2", 32'(ex_alusrc2), 32'd0);
        check("rst_wb_regwrite", 32'(wb_regwrite), 32'd0);
        check("rst_wb_dst", 32'(wb_dst), 32'd0);
        check("rst_mdu_busy", 32'(mdu_busy), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_flush", 32'(flush_if_id), 32'd0);

        // lw $8,0($1) then add $9,$8,$10
        instr(1'b1, 6'h23, 6'h00, 5'd1, 5'd8, 5'd0);
        #1;
        check("lw_stall", 32'(stall), 32'd0);
        check("lw_pcsrc", 32'(id_pcsrc), 32'd0);
        step();
        check("lw_ex_alusrc2", 32'(ex_alusrc2), 32'd1);
        check("lw_ex_extop", 32'(ex_extop), 32'd1);
        instr(1'b1, 6'h00, 6'h20, 5'd8, 5'd10, 5'd9);
        #1;
        check("lu_stall_on", 32'(stall), 32'd1);
        check("lu_flush", 32'(flush_if_id), 32'd0);
        step();
        check("lu_bubble_alusrc2", 32'(ex_alusrc2), 32'd0);
        check("lu_bubble_extop", 32'(ex_extop), 32'd0);
        check("lu_mem_memread", 32'(mem_memread), 32'd1);
        check("lu_stall_off", 32'(stall), 32'd0);
        step();
        idle();
        check("lw_wb_dst", 32'(wb_dst), 32'd8);
        check("lw_wb_memtoreg", 32'(wb_memtoreg), 32'd1);
        check("lw_wb_regwrite", 32'(wb_regwrite), 32'd1);
        step();
        check("bubble_wb_regwrite", 32'(wb_regwrite), 32'd0);
        step();
        check("add_wb_dst", 32'(wb_dst), 32'd9);
        check("add_wb_memtoreg", 32'(wb_memtoreg), 32'd0);
        check("add_wb_regwrite", 32'(wb_regwrite), 32'd1);

        // taken branch overrides a load-use stall
        instr(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0);
        step();
        instr(1'b1, 6'h00, 6'h20, 5'd5, 5'd5, 5'd6);
        ex_branch_taken = 1'b1;
        #1;
        check("br_stall", 32'(stall), 32'd0);
        check("br_flush", 32'(flush_if_id), 32'd1);
        step();
        ex_branch_taken = 1'b0;
        idle();
        check("br_ex_extop", 32'(ex_extop), 32'd0);
        check("br_ex_alusrc2", 32'(ex_alusrc2), 32'd0);
        check("br_ex_branch", 32'(ex_branch), 32'd0);
        check("br_mem_memread", 32'(mem_memread), 32'd1);

        // jal
        instr(1'b1, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0);
        #1;
        check("jal_pcsrc", 32'(id_pcsrc), 32'd2);
        check("jal_flush", 32'(flush_if_id), 32'd1);
        step();
        idle();
        step();
        step();
        check("jal_wb_dst", 32'(wb_dst), 32'd31);
        check("jal_wb_memtoreg", 32'(wb_memtoreg), 32'd2);
        check("jal_wb_regwrite", 32'(wb_regwrite), 32'd1);

        // jr select (combinational only, never clocked in)
        instr(1'b1, 6'h00, 6'h08, 5'd31, 5'd0, 5'd0);
        #1;
        check("jr_pcsrc", 32'(id_pcsrc), 32'd3);
        check("jr_flush", 32'(flush_if_id), 32'd1);
        idle();
        #1;
        check("idle_pcsrc", 32'(id_pcsrc), 32'd0);

        // sll, lui, sw, andi, beq decode through EX/MEM
        instr(1'b1, 6'h00, 6'h00, 5'd0, 5'd3, 5'd2);
        step();
        check("sll_ex_alusrc1", 32'(ex_alusrc1), 32'd1);
        check("sll_ex_alusrc2", 32'(ex_alusrc2), 32'd0);
        instr(1'b1, 6'h0f, 6'h00, 5'd0, 5'd4, 5'd0);
        step();
        check("lui_ex_luop", 32'(ex_luop), 32'd1);
        check("lui_ex_alusrc2", 32'(ex_alusrc2), 32'd1);
        check("lui_ex_alusrc1", 32'(ex_alusrc1), 32'd0);
        instr(1'b1, 6'h2b, 6'h00, 5'd1, 5'd2, 5'd0);
        step();
        check("sw_ex_extop", 32'(ex_extop), 32'd1);
        check("sw_ex_luop", 32'(ex_luop), 32'd0);
        instr(1'b1, 6'h0c, 6'h00, 5'd1, 5'd6, 5'd0);
        step();
        check("andi_ex_extop", 32'(ex_extop), 32'd0);
        check("andi_ex_alusrc2", 32'(ex_alusrc2), 32'd1);
        check("sw_mem_memwrite", 32'(mem_memwrite), 32'd1);
        instr(1'b1, 6'h04, 6'h00, 5'd7, 5'd7, 5'd0);
        #1;
        check("beq_pcsrc", 32'(id_pcsrc), 32'd1);
        step();
        idle();
        check("beq_ex_branch", 32'(ex_branch), 32'd1);
        check("andi_mem_memwrite", 32'(mem_memwrite), 32'd0);

        // add $7 then add $0: the $0 write is suppressed
        instr(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd7);
        step();
        instr(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd0);
        step();
        idle();
        step();
        check("add7_wb_dst", 32'(wb_dst), 32'd7);
        check("add7_wb_regwrite", 32'(wb_regwrite), 32'd1);
        step();
        check("add0_wb_regwrite", 32'(wb_regwrite), 32'd0);
        check("add0_wb_dst", 32'(wb_dst), 32'd0);

        // mult then mflo $11: busy for exactly 4 cycles, mflo held meanwhile
        step();
        instr(1'b1, 6'h00, 6'h18, 5'd1, 5'd2, 5'd0);
        #1;
        check("mult_stall", 32'(stall), 32'd0);
        step();
        check("mdu_busy_c1", 32'(mdu_busy), 32'd1);
        instr(1'b1, 6'h00, 6'h12, 5'd0, 5'd0, 5'd11);
        #1;
        check("mflo_stall_c1", 32'(stall), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mdu_busy_hold", 32'(mdu_busy), 32'd1);
            check("mflo_stall_hold", 32'(stall), 32'd1);
        end
        step();
        check("mdu_busy_drop", 32'(mdu_busy), 32'd0);
        check("mflo_stall_drop", 32'(stall), 32'd0);
        step();
        idle();
        step();
        step();
        check("mflo_wb_dst", 32'(wb_dst), 32'd11);
        check("mflo_wb_regwrite", 32'(wb_regwrite), 32'd1);

        // reset in the middle of an MDU operation (count 3) with a load in EX
        instr(1'b1, 6'h00, 6'h18, 5'd1, 5'd2, 5'd0);
        step();
        instr(1'b1, 6'h23, 6'h00, 5'd1, 5'd12, 5'd0);
        step();
        check("pre_rst_busy", 32'(mdu_busy), 32'd1);
        check("pre_rst_ex_extop", 32'(ex_extop), 32'd1);
        reset = 1'b1;
        idle();
        step();
        check("mrst_busy", 32'(mdu_busy), 32'd0);
        check("mrst_ex_extop", 32'(ex_extop), 32'd0);
        check("mrst_ex_alusrc2", 32'(ex_alusrc2), 32'd0);
        check("mrst_mem_memread", 32'(mem_memread), 32'd0);
        check("mrst_wb_regwrite", 32'(wb_regwrite), 32'd0);
        check("mrst_wb_dst", 32'(wb_dst), 32'd0);
        check("mrst_stall", 32'(stall), 32'd0);
        reset = 1'b0;

        // no forwarding: add $3 then sub $4,$3,$5 -> two stall cycles
        instr(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3);
        step();
        instr(1'b1, 6'h00, 6'h22, 5'd3, 5'd5, 5'd4);
        #1;
        check("nf_stall_c1", 32'(nf_stall), 32'd1);
        check("fwd_no_stall", 32'(stall), 32'd0);
        step();
        check("nf_stall_c2", 32'(nf_stall), 32'd1);
        step();
        check("nf_stall_c3", 32'(nf_stall), 32'd0);
        check("nf_add_wb_dst", 32'(nf_wb_dst), 32'd3);
        check("nf_add_wb_regwrite", 32'(nf_wb_regwrite), 32'd1);
        step();
        idle();
        step();
        step();
        check("nf_sub_wb_dst", 32'(nf_wb_dst), 32'd4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
